spi_master_seq: RTL

// - Host-side SPI transaction sequencer that drives the SPI slave (SS_n/MOSI, samples MISO).
// - Turns one host request (write or read of an 8-bit address) into two 10-bit slave frames.
// - Write = WR_ADDR frame + WR_DATA frame; read = RD_ADDR frame + RD_DATA frame with 8-bit MISO capture.
// - Sits between a register/CPU port and the SPI slave + RAM pair; one transaction in flight.

---
 rtl/spi_master_seq_pkg.sv | 53 +++++
 rtl/spi_frame_engine.sv | 117 +++++++++++
 rtl/spi_master_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_master_seq_pkg.sv
// Shared types and constants for the SPI master transaction sequencer.
// Frame commands, state encodings and frame-word helpers.
package spi_master_seq_pkg;

   localparam int unsigned FRAME_W   = 10;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BIT_CNT_W = 4;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      M_IDLE,
      M_START,
      M_SHIFT,
      M_LATCH,
      M_WAIT_MISO,
      M_CAPTURE,
      M_GAP
   } m_state_t;

   typedef enum logic [1:0] {
      SQ_IDLE,
      SQ_FRAME1,
      SQ_GAP,
      SQ_FRAME2
   } seq_state_t;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_t;

   // Fields needed after the first frame has been launched.
   typedef struct packed {
      op_t              op;
      logic [DATA_W-1:0] wdata;
   } req_hold_t;

   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return int'($clog2(m + 1));
   endfunction

   function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] cmd,
                                                     input logic [DATA_W-1:0] payload);
      return {cmd, payload};
   endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// Runs a single 10-bit SPI slave frame: select, command dwell, shift, latch,
// and for RD_DATA frames the delayed 8-bit MISO capture.
module spi_frame_engine
   import spi_master_seq_pkg::*;
#(
   parameter int unsigned MISO_START = 3,
   parameter int unsigned CNT_W      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [FRAME_W-1:0] i_word,
   input  logic               i_is_rd_data,
   input  logic               i_miso,
   output logic               o_ss_n,
   output logic               o_mosi,
   output logic [DATA_W-1:0]  o_cap_data,
   output logic               o_frame_done_c
);

   m_state_t             r_state;
   logic [FRAME_W-1:0]   r_shift;
   logic [BIT_CNT_W-1:0] r_bits;
   logic [CNT_W-1:0]     r_wait;
   logic                 r_is_rd;
   logic [DATA_W-1:0]    r_cap;
   logic                 r_ss_n;
   logic                 r_mosi;
   logic [DATA_W-1:0]    r_cap_data;

   // High on the last low cycle of the frame; SS_n rises on the following cycle.
   assign o_frame_done_c = ((r_state == M_LATCH) && !r_is_rd) ||
                           ((r_state == M_CAPTURE) && (r_bits == '0));

   assign o_ss_n     = r_ss_n;
   assign o_mosi     = r_mosi;
   assign o_cap_data = r_cap_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= M_IDLE;
         r_shift    <= '0;
         r_bits     <= '0;
         r_wait     <= '0;
         r_is_rd    <= 1'b0;
         r_cap      <= '0;
         r_ss_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_cap_data <= '0;
      end else begin
         case (r_state)
            M_IDLE: begin
               if (i_start) begin
                  r_state <= M_START;
                  r_shift <= i_word;
                  r_is_rd <= i_is_rd_data;
                  r_ss_n  <= 1'b0;
                  r_mosi  <= i_word[FRAME_W-1];
                  r_bits  <= BIT_CNT_W'(1);
               end
            end
            M_START: begin
               if (r_bits != '0) begin
                  r_bits <= r_bits - BIT_CNT_W'(1);
               end else begin
                  r_state <= M_SHIFT;
                  r_mosi  <= r_shift[FRAME_W-1];
                  r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                  r_bits  <= BIT_CNT_W'(FRAME_W - 1);
               end
            end
            M_SHIFT: begin
               if (r_bits != '0) begin
                  r_mosi  <= r_shift[FRAME_W-1];
                  r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                  r_bits  <= r_bits - BIT_CNT_W'(1);
               end else begin
                  r_state <= M_LATCH;
                  r_mosi  <= 1'b0;
               end
            end
            M_LATCH: begin
               if (!r_is_rd) begin
                  r_state <= M_IDLE;
                  r_ss_n  <= 1'b1;
               end else if (MISO_START > 1) begin
                  r_state <= M_WAIT_MISO;
                  r_wait  <= CNT_W'(MISO_START - 2);
               end else begin
                  r_state <= M_CAPTURE;
                  r_bits  <= BIT_CNT_W'(DATA_W - 1);
               end
            end
            M_WAIT_MISO: begin
               if (r_wait != '0) begin
                  r_wait <= r_wait - CNT_W'(1);
               end else begin
                  r_state <= M_CAPTURE;
                  r_bits  <= BIT_CNT_W'(DATA_W - 1);
               end
            end
            M_CAPTURE: begin
               r_cap <= {r_cap[DATA_W-2:0], i_miso};
               if (r_bits != '0) begin
                  r_bits <= r_bits - BIT_CNT_W'(1);
               end else begin
                  r_state    <= M_IDLE;
                  r_ss_n     <= 1'b1;
                  r_cap_data <= {r_cap[DATA_W-2:0], i_miso};
               end
            end
            default: r_state <= M_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/spi_master_seq.sv
// Host-side SPI sequencer: turns one read/write request into an address frame
// followed by a data frame, with a fixed SS_n-high gap between them.
module spi_master_seq
   import spi_master_seq_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned MISO_START = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_op,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, MISO_START);

   seq_state_t         r_state;
   req_hold_t          r_req;
   logic [CNT_W-1:0]   r_gap;
   logic               r_done;
   logic               r_busy;

   logic               w_accept;
   logic               w_start;
   logic               w_frame_done;
   logic               w_is_rd_data;
   logic [FRAME_W-1:0] w_first_word;
   logic [FRAME_W-1:0] w_second_word;
   logic [FRAME_W-1:0] w_word;
   logic [DATA_W-1:0]  w_cap_data;

   // Ready is withheld during the done cycle so consecutive transactions keep an SS_n gap.
   assign req_ready = (r_state == SQ_IDLE) && !r_done;
   assign w_accept  = req_valid && req_ready;

   // The address frame launches straight from the request inputs on the accepting edge.
   assign w_first_word  = make_frame((op_t'(req_op) == OP_RD) ? RD_ADDR : WR_ADDR, req_addr);
   assign w_second_word = (r_req.op == OP_RD) ? make_frame(RD_DATA, 8'h00)
                                              : make_frame(WR_DATA, r_req.wdata);
   assign w_word        = w_accept ? w_first_word : w_second_word;
   assign w_is_rd_data  = !w_accept && (r_req.op == OP_RD);
   assign w_start       = w_accept || ((r_state == SQ_GAP) && (r_gap == '0));

   assign done  = r_done;
   assign busy  = r_busy;
   assign rdata = w_cap_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= SQ_IDLE;
         r_req   <= '0;
         r_gap   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            SQ_IDLE: begin
               if (w_accept) begin
                  r_state     <= SQ_FRAME1;
                  r_req.op    <= op_t'(req_op);
                  r_req.wdata <= req_wdata;
                  r_busy      <= 1'b1;
               end
            end
            SQ_FRAME1: begin
               if (w_frame_done) begin
                  r_state <= SQ_GAP;
                  r_gap   <= CNT_W'(GAP_CYCLES - 1);
               end
            end
            SQ_GAP: begin
               if (r_gap != '0) begin
                  r_gap <= r_gap - CNT_W'(1);
               end else begin
                  r_state <= SQ_FRAME2;
               end
            end
            SQ_FRAME2: begin
               if (w_frame_done) begin
                  r_state <= SQ_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= SQ_IDLE;
         endcase
      end
   end

   spi_frame_engine #(
      .MISO_START (MISO_START),
      .CNT_W      (CNT_W)
   ) u_frame (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (w_start),
      .i_word         (w_word),
      .i_is_rd_data   (w_is_rd_data),
      .i_miso         (MISO),
      .o_ss_n         (SS_n),
      .o_mosi         (MOSI),
      .o_cap_data     (w_cap_data),
      .o_frame_done_c (w_frame_done)
   );

endmodule
